// File: rtl/vdp_vram_arb.sv
// VRAM arbiter: display fetch vs. host data/control ports, with read-ahead buffer.
// Optional CPU starvation guard enabled by defining VDP_VRAM_STARVE_GUARD_EN.
module vdp_vram_arb #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_tick,
    input  logic              rd_tick,
    input  logic              mode,
    input  logic [7:0]        din,
    output logic [7:0]        cpu_dout,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic              disp_valid,
    output logic [7:0]        disp_data,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [7:0]        vram_din,
    input  logic [7:0]        vram_dout,
    output logic              overrun
);

    typedef enum logic {IDLE, RD_CAP} state_t;

    state_t            state;
    state_t            state_next;
    logic              latch;
    logic [7:0]        lo;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wbuf;
    logic              pend_wr;
    logic              pend_rd;
    logic              disp_grant;
    logic              cpu_wr_go;
    logic              cpu_rd_go;
    logic              force_cpu;
    logic              stale;
    logic [13:0]       load_raw;
    logic [ADDR_W-1:0] load_addr;

    // Second control byte carries the upper six address bits above the latched low byte.
    assign load_raw  = {din[5:0], lo};
    assign load_addr = ADDR_W'(load_raw);

`ifdef VDP_VRAM_STARVE_GUARD_EN
    logic [2:0] starve_cnt;
    logic       cpu_serve;

    assign cpu_serve = cpu_wr_go | cpu_rd_go;
    assign force_cpu = (starve_cnt == 3'd7) && (state == IDLE) && (pend_wr || pend_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (cpu_serve || !(pend_wr || pend_rd)) begin
            starve_cnt <= '0;
        end else if (disp_grant && (state == IDLE) && (starve_cnt != 3'd7)) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign force_cpu = 1'b0;
`endif

    always_comb begin
        state_next = state;
        disp_grant = disp_req && !force_cpu;
        disp_ack   = 1'b0;
        vram_addr  = addr;
        vram_we    = 1'b0;
        cpu_wr_go  = 1'b0;
        cpu_rd_go  = 1'b0;
        if (disp_grant) begin
            disp_ack  = 1'b1;
            vram_addr = disp_addr;
        end
        case (state)
            IDLE: begin
                if (!disp_grant) begin
                    if (pend_wr) begin
                        cpu_wr_go = 1'b1;
                        vram_we   = !reset;
                    end else if (pend_rd) begin
                        cpu_rd_go  = 1'b1;
                        state_next = RD_CAP;
                    end
                end
            end
            RD_CAP: state_next = IDLE;
        endcase
    end

    assign vram_din  = wbuf;
    assign disp_data = vram_dout;

    // A host tick replacing an op that is not being served this cycle is an overrun.
    assign stale = (pend_wr && !cpu_wr_go) || (pend_rd && !cpu_rd_go);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            latch      <= 1'b0;
            lo         <= '0;
            addr       <= '0;
            wbuf       <= '0;
            cpu_dout   <= '0;
            pend_wr    <= 1'b0;
            pend_rd    <= 1'b0;
            disp_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            disp_valid <= disp_ack;
            overrun    <= 1'b0;

            if (cpu_wr_go) begin
                pend_wr <= 1'b0;
                addr    <= addr + ADDR_W'(1);
            end
            if (cpu_rd_go) begin
                pend_rd <= 1'b0;
            end
            if (state == RD_CAP) begin
                cpu_dout <= vram_dout;
                addr     <= addr + ADDR_W'(1);
            end

            // Host accesses come last so a new op or address load wins over service updates.
            if (mode) begin
                if (wr_tick) begin
                    if (!latch) begin
                        lo    <= din;
                        latch <= 1'b1;
                    end else begin
                        latch <= 1'b0;
                        if (!din[7]) begin
                            addr    <= load_addr;
                            pend_wr <= 1'b0;
                            pend_rd <= !din[6];
                        end
                    end
                end else if (rd_tick) begin
                    latch <= 1'b0;
                end
            end else if (wr_tick) begin
                wbuf     <= din;
                cpu_dout <= din;
                pend_wr  <= 1'b1;
                pend_rd  <= 1'b0;
                overrun  <= stale;
            end else if (rd_tick) begin
                pend_rd  <= 1'b1;
                pend_wr  <= 1'b0;
                overrun  <= stale;
            end
        end
    end

endmodule
